// File: rtl/spike_gen_pkg.sv
// Shared encodings and constants for the spike train generator and its classifier.
// Jitter-related constants are only consumed when JITTER_EN is defined.
package spike_gen_pkg;

    localparam int SAMPLE_RATE       = 2000;
    localparam int QUIET_DEFAULT     = 16000;
    localparam int JBITS             = 4;
    localparam int MAX_EXCITABILITY  = 100;
    localparam int DECAY_STEP_PERIOD = 8 * SAMPLE_RATE;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [1:0] EV_C   = 2'b00;
    localparam logic [1:0] EV_B   = 2'b01;
    localparam logic [1:0] EV_A   = 2'b10;
    localparam logic [1:0] EV_INV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_QUIET,
        S_FINISH
    } gen_state_t;

    // Anything below one cycle of spacing degenerates to back-to-back pulses.
    function automatic logic [15:0] clamp_isi(input logic [15:0] isi);
        return (isi < 16'd2) ? 16'd1 : isi;
    endfunction

    function automatic logic [15:0] quiet_len(input logic [15:0] q);
        return (q == 16'd0) ? 16'(QUIET_DEFAULT) : q;
    endfunction

endpackage

// File: rtl/spike_train_gen_lfsr16.sv
// 16-bit Galois LFSR (right shift), reloaded with seed on reset, advances when step is high.
module lfsr16
    import spike_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= seed;
        else if (step)
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/spike_train_gen.sv
// Detection pulse train generator: turns a class/count/spacing command into a pulse train.
// Optional feature: define JITTER_EN to add LFSR-driven jitter to every inter-pulse gap.
module spike_train_gen
    import spike_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_class,
    input  logic [7:0]  cmd_count,
    input  logic [15:0] isi_a_in,
    input  logic [15:0] isi_b_in,
    input  logic [15:0] quiet_in,
    input  logic        abort,
    output logic        detection,
    output logic        busy,
    output logic        done,
    output logic        cmd_err,
    output logic [7:0]  pulses_sent
);

    gen_state_t  state, state_nxt;
    logic [7:0]  count_r;
    logic [15:0] isi_r;
    logic [15:0] cnt;
    logic [15:0] gap_span;
    logic        accept;
    logic        last_pulse;

    assign cmd_ready  = (state == S_IDLE) && !reset;
    assign busy       = (state != S_IDLE);
    assign accept     = cmd_valid && cmd_ready && !abort;
    assign last_pulse = ((pulses_sent + 8'd1) == count_r);

`ifdef JITTER_EN
    logic [15:0] lfsr_q;
    logic [16:0] span_w;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (state == S_PULSE),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign span_w   = {1'b0, isi_r} + {{(17-JBITS){1'b0}}, lfsr_q[JBITS-1:0]};
    assign gap_span = span_w[16] ? 16'hFFFF : span_w[15:0];
`else
    assign gap_span = isi_r;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        detection = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_class)
                        EV_A, EV_B: state_nxt = (cmd_count == 8'd0) ? S_FINISH : S_PULSE;
                        EV_C:       state_nxt = S_QUIET;
                        default:    state_nxt = S_IDLE;
                    endcase
                end
            end
            S_PULSE: begin
                detection = 1'b1;
                if (last_pulse)
                    state_nxt = S_FINISH;
                else if (gap_span <= 16'd1)
                    state_nxt = S_PULSE;
                else
                    state_nxt = S_GAP;
            end
            S_GAP: begin
                if (cnt == 16'd0)
                    state_nxt = S_PULSE;
            end
            S_QUIET: begin
                if (cnt == 16'd0)
                    state_nxt = S_FINISH;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort wins over everything, including a pulse or done due this cycle.
        if (abort) begin
            state_nxt = S_IDLE;
            detection = 1'b0;
            done      = 1'b0;
        end
    end

    // The shared downcounter times both GAP (span-2) and QUIET (length-1).
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r     <= '0;
            isi_r       <= '0;
            cnt         <= '0;
            pulses_sent <= '0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (accept) begin
                pulses_sent <= '0;
                count_r     <= cmd_count;
                isi_r       <= clamp_isi((cmd_class == EV_A) ? isi_a_in : isi_b_in);
                cnt         <= quiet_len(quiet_in) - 16'd1;
                cmd_err     <= (cmd_class == EV_INV);
            end else if (!abort) begin
                case (state)
                    S_PULSE: begin
                        pulses_sent <= pulses_sent + 8'd1;
                        cnt         <= (gap_span > 16'd1) ? gap_span - 16'd2 : 16'd0;
                    end
                    S_GAP, S_QUIET: begin
                        if (cnt != 16'd0)
                            cnt <= cnt - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_train_gen.sv
// Directed bench for spike_train_gen: pulse timing, quiet trains, invalid class, abort and reset.
module tb_spike_train_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_class;
    logic [7:0]  cmd_count;
    logic [15:0] isi_a_in, isi_b_in, quiet_in;
    logic        abort;
    logic        detection, busy, done, cmd_err;
    logic [7:0]  pulses_sent;

    int n_checks = 0;
    int n_err    = 0;

    int pulse_q[$];
    int done_at, err_at, busy_k1, ready_k1, busy_post, ready_post;

    always #5 clk = ~clk;

    spike_train_gen dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_class   (cmd_class),
        .cmd_count   (cmd_count),
        .isi_a_in    (isi_a_in),
        .isi_b_in    (isi_b_in),
        .quiet_in    (quiet_in),
        .abort       (abort),
        .detection   (detection),
        .busy        (busy),
        .done        (done),
        .cmd_err     (cmd_err),
        .pulses_sent (pulses_sent)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Offers one command for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [1:0] cls, input logic [7:0] cnt, input logic [15:0] ia,
                         input logic [15:0] ib, input logic [15:0] q, input logic ab);
        @(negedge clk);
        cmd_class = cls; cmd_count = cnt; isi_a_in = ia; isi_b_in = ib; quiet_in = q;
        cmd_valid = 1'b1; abort = ab;
        @(posedge clk); #1;
        cmd_valid = 1'b0; abort = 1'b0;
    endtask

    // Samples cycles +1..+max_k mid-cycle; abort is held high during cycle abort_at.
    task automatic run(input int max_k, input int abort_at);
        pulse_q.delete();
        done_at = 0; err_at = 0; busy_post = -1; ready_post = -1;
        for (int k = 1; k <= max_k; k++) begin
            abort = (k == abort_at);
            @(negedge clk);
            if (detection) pulse_q.push_back(k);
            if (cmd_err && err_at == 0) err_at = k;
            if (k == 1) begin busy_k1 = int'(busy); ready_k1 = int'(cmd_ready); end
            if (abort_at != 0 && k == abort_at + 1) begin
                busy_post = int'(busy); ready_post = int'(cmd_ready);
            end
            if (done) begin done_at = k; break; end
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    task automatic check_train(input string tag, input int n, input int isi, input int exp_done);
        chk({tag, "_npulse"}, pulse_q.size(), n);
        for (int i = 0; i < pulse_q.size() && i < n; i++)
            chk({tag, "_pulse_pos"}, pulse_q[i], 1 + i * isi);
        chk({tag, "_done_at"}, done_at, exp_done);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_class = 2'b00; cmd_count = 8'd0;
        isi_a_in = 16'd0; isi_b_in = 16'd0; quiet_in = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_detection", int'(detection), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        chk("rst_pulses_sent", int'(pulses_sent), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);

        // Class A: six pulses every 10 cycles, done right after the last one.
        issue(2'b10, 8'd6, 16'd10, 16'd0, 16'd0, 1'b0);
        run(100, 0);
        check_train("a6", 6, 10, 52);
        chk("a6_busy_k1", busy_k1, 1);
        chk("a6_ready_k1", ready_k1, 0);
        chk("a6_pulses_sent", int'(pulses_sent), 6);
        @(negedge clk);
        chk("a6_pulses_hold", int'(pulses_sent), 6);
        chk("a6_idle_after", int'(busy), 0);

        // Class B with ISI 1 and 0: back-to-back pulses.
        issue(2'b01, 8'd2, 16'd0, 16'd1, 16'd0, 1'b0);
        run(20, 0);
        check_train("b_isi1", 2, 1, 3);
        issue(2'b01, 8'd2, 16'd0, 16'd0, 16'd0, 1'b0);
        run(20, 0);
        check_train("b_isi0", 2, 1, 3);

        // Class C quiet trains.
        issue(2'b00, 8'd3, 16'd0, 16'd0, 16'd0, 1'b0);
        run(16100, 0);
        check_train("c_default", 0, 1, 16001);
        issue(2'b00, 8'd0, 16'd0, 16'd0, 16'd5, 1'b0);
        run(50, 0);
        check_train("c_q5", 0, 1, 6);

        // Invalid class: error pulse only, stays ready.
        issue(2'b11, 8'd4, 16'd3, 16'd3, 16'd0, 1'b0);
        run(8, 0);
        check_train("inv", 0, 1, 0);
        chk("inv_err_at", err_at, 1);
        chk("inv_ready_k1", ready_k1, 1);
        chk("inv_busy_k1", busy_k1, 0);

        issue(2'b10, 8'd0, 16'd7, 16'd0, 16'd0, 1'b0);
        run(20, 0);
        check_train("a0", 0, 1, 1);
        chk("a0_pulses_sent", int'(pulses_sent), 0);

        // Abort in a GAP.
        issue(2'b10, 8'd10, 16'd100, 16'd0, 16'd0, 1'b0);
        run(160, 150);
        check_train("abort_gap", 2, 100, 0);
        chk("abort_gap_busy_post", busy_post, 0);
        chk("abort_gap_ready_post", ready_post, 1);
        chk("abort_gap_pulses_sent", int'(pulses_sent), 2);

        // Abort on a pulse cycle suppresses that pulse.
        issue(2'b10, 8'd3, 16'd4, 16'd0, 16'd0, 1'b0);
        run(20, 5);
        check_train("abort_pulse", 1, 4, 0);
        chk("abort_pulse_busy_post", busy_post, 0);
        chk("abort_pulse_pulses_sent", int'(pulses_sent), 1);

        // Abort coinciding with accept drops the command.
        issue(2'b10, 8'd3, 16'd4, 16'd0, 16'd0, 1'b1);
        run(10, 0);
        check_train("abort_acc", 0, 4, 0);
        chk("abort_acc_busy_k1", busy_k1, 0);

        // Synchronous reset mid-train, landing where pulse 3 would occur.
        issue(2'b10, 8'd10, 16'd3, 16'd0, 16'd0, 1'b0);
        run(5, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_detection", int'(detection), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cmd_err", int'(cmd_err), 0);
        chk("midrst_pulses_sent", int'(pulses_sent), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_ready", int'(cmd_ready), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
